// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: I-side burst refills and D-side burst refills/single stores share one
// external memory port with round-robin arbitration and per-beat ready handshake.
module mem_arbiter #(
  parameter int BURST_LEN = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              mem_req,
  output logic              mem_wb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic                store_q, store_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                last_d_q, last_d_d;   // 1 = D side received the most recent grant
  logic                i_rvalid_q, i_rvalid_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic                i_done_q, i_done_d;
  logic                d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                d_done_q, d_done_d;

  logic i_elig, d_elig, last_beat;

  // A side whose done pulse is showing this cycle sits out one arbitration round.
  assign i_elig    = i_req & ~i_done_q;
  assign d_elig    = d_req & ~d_done_q;
  assign last_beat = store_q | (beat_q == BEAT_W'(BURST_LEN - 1));

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    base_d     = base_q;
    store_d    = store_q;
    wdata_d    = wdata_q;
    last_d_d   = last_d_q;
    i_rvalid_d = 1'b0;
    i_rdata_d  = '0;
    i_done_d   = 1'b0;
    d_rvalid_d = 1'b0;
    d_rdata_d  = '0;
    d_done_d   = 1'b0;
    mem_req    = 1'b0;
    mem_wb     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;

    case (state_q)
      IDLE: begin
        if (d_elig && (!i_elig || !last_d_q)) begin
          state_d  = BUSY_D;
          base_d   = d_addr;
          store_d  = d_we;
          wdata_d  = d_wdata;
          beat_d   = '0;
          last_d_d = 1'b1;
        end else if (i_elig) begin
          state_d  = BUSY_I;
          base_d   = i_addr;
          store_d  = 1'b0;
          wdata_d  = '0;
          beat_d   = '0;
          last_d_d = 1'b0;
        end
      end
      BUSY_I, BUSY_D: begin
        mem_req   = 1'b1;
        mem_addr  = base_q + (ADDR_W'(beat_q) << 2);
        mem_wb    = (state_q == BUSY_D) && store_q;
        mem_wdata = mem_wb ? wdata_q : '0;
        if (mem_ready) begin
          if (!store_q) begin
            if (state_q == BUSY_I) begin
              i_rvalid_d = 1'b1;
              i_rdata_d  = mem_rdata;
            end else begin
              d_rvalid_d = 1'b1;
              d_rdata_d  = mem_rdata;
            end
          end
          if (last_beat) begin
            state_d = IDLE;
            if (state_q == BUSY_I) i_done_d = 1'b1;
            else                   d_done_d = 1'b1;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset defaults last_d to 0 so the first simultaneous request goes to D.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      base_q     <= '0;
      store_q    <= 1'b0;
      wdata_q    <= '0;
      last_d_q   <= 1'b0;
      i_rvalid_q <= 1'b0;
      i_rdata_q  <= '0;
      i_done_q   <= 1'b0;
      d_rvalid_q <= 1'b0;
      d_rdata_q  <= '0;
      d_done_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      base_q     <= base_d;
      store_q    <= store_d;
      wdata_q    <= wdata_d;
      last_d_q   <= last_d_d;
      i_rvalid_q <= i_rvalid_d;
      i_rdata_q  <= i_rdata_d;
      i_done_q   <= i_done_d;
      d_rvalid_q <= d_rvalid_d;
      d_rdata_q  <= d_rdata_d;
      d_done_q   <= d_done_d;
    end
  end

  assign i_rvalid = i_rvalid_q;
  assign i_rdata  = i_rdata_q;
  assign i_done   = i_done_q;
  assign d_rvalid = d_rvalid_q;
  assign d_rdata  = d_rdata_q;
  assign d_done   = d_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model compared every cycle, plus directed
// scenarios with hand-computed literal expectations.
module tb_mem_arbiter;
  localparam int BL = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ready = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic        i_rvalid, i_done, d_rvalid, d_done, mem_req, mem_wb;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

  mem_arbiter #(.BURST_LEN(BL), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_done(d_done),
    .mem_req(mem_req), .mem_wb(mem_wb), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5A5_5A5A;
  endfunction

  assign mem_rdata = rd_fn(mem_addr);

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the port, how many beats are done, and what shows next cycle.
  int          m_owner = 0;          // 0 none, 1 I, 2 D
  bit          m_store = 1'b0;
  bit          m_last_d = 1'b0;
  int          m_beats = 0;
  logic [31:0] m_base = '0, m_wdata = '0;
  bit          e_i_rv = 1'b0, e_i_dn = 1'b0, e_d_rv = 1'b0, e_d_dn = 1'b0;
  logic [31:0] e_i_rd = '0, e_d_rd = '0;

  always @(posedge clk) begin
    bit          n_i_rv, n_i_dn, n_d_rv, n_d_dn, i_el, d_el;
    logic [31:0] n_i_rd, n_d_rd, a;
    int          pick;
    if (!rst) begin
      m_owner = 0; m_store = 1'b0; m_last_d = 1'b0; m_beats = 0; m_base = '0; m_wdata = '0;
      e_i_rv = 1'b0; e_i_dn = 1'b0; e_d_rv = 1'b0; e_d_dn = 1'b0; e_i_rd = '0; e_d_rd = '0;
    end else begin
      n_i_rv = 1'b0; n_i_dn = 1'b0; n_d_rv = 1'b0; n_d_dn = 1'b0; n_i_rd = '0; n_d_rd = '0;
      if (m_owner == 0) begin
        i_el = i_req && !e_i_dn;
        d_el = d_req && !e_d_dn;
        if (i_el && d_el) pick = m_last_d ? 1 : 2;
        else if (d_el)    pick = 2;
        else if (i_el)    pick = 1;
        else              pick = 0;
        if (pick == 2) begin
          m_owner = 2; m_base = d_addr; m_store = d_we; m_wdata = d_wdata; m_beats = 0; m_last_d = 1'b1;
        end else if (pick == 1) begin
          m_owner = 1; m_base = i_addr; m_store = 1'b0; m_wdata = '0; m_beats = 0; m_last_d = 1'b0;
        end
      end else if (mem_ready) begin
        a = m_base + 32'(4 * m_beats);
        if (!m_store) begin
          if (m_owner == 1) begin n_i_rv = 1'b1; n_i_rd = rd_fn(a); end
          else              begin n_d_rv = 1'b1; n_d_rd = rd_fn(a); end
        end
        m_beats++;
        if (m_beats == (m_store ? 1 : BL)) begin
          if (m_owner == 1) n_i_dn = 1'b1; else n_d_dn = 1'b1;
          m_owner = 0;
        end
      end
      e_i_rv = n_i_rv; e_i_rd = n_i_rd; e_i_dn = n_i_dn;
      e_d_rv = n_d_rv; e_d_rd = n_d_rd; e_d_dn = n_d_dn;
    end
  end

  // Monotonic logs for the directed checks; tests take snapshots instead of clearing.
  logic [31:0] log_addr[$];
  logic [31:0] log_wdata[$];
  bit          log_wb[$];
  byte         order_q[$];
  int          n_irv = 0, n_drv = 0, n_idn = 0, n_ddn = 0, n_i_coinc = 0;

  always @(negedge clk) begin
    bit          x_req, x_wb;
    logic [31:0] x_addr, x_wdata;
    if (!rst) begin
      chk("rst_mem_req", mem_req, 0);     chk("rst_mem_wb", mem_wb, 0);
      chk("rst_mem_addr", mem_addr, 0);   chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_i_rvalid", i_rvalid, 0);   chk("rst_i_rdata", i_rdata, 0);
      chk("rst_i_done", i_done, 0);       chk("rst_d_rvalid", d_rvalid, 0);
      chk("rst_d_rdata", d_rdata, 0);     chk("rst_d_done", d_done, 0);
    end else begin
      x_req   = (m_owner != 0);
      x_addr  = x_req ? m_base + 32'(4 * m_beats) : 32'h0;
      x_wb    = (m_owner == 2) && m_store;
      x_wdata = x_wb ? m_wdata : 32'h0;
      chk("mem_req", mem_req, x_req);     chk("mem_addr", mem_addr, x_addr);
      chk("mem_wb", mem_wb, x_wb);        chk("mem_wdata", mem_wdata, x_wdata);
      chk("i_rvalid", i_rvalid, e_i_rv);  chk("i_done", i_done, e_i_dn);
      chk("d_rvalid", d_rvalid, e_d_rv);  chk("d_done", d_done, e_d_dn);
      if (e_i_rv) chk("i_rdata", i_rdata, e_i_rd);
      if (e_d_rv) chk("d_rdata", d_rdata, e_d_rd);
      if (mem_req && mem_ready) begin
        log_addr.push_back(mem_addr); log_wdata.push_back(mem_wdata); log_wb.push_back(mem_wb);
      end
      if (i_rvalid) n_irv++;
      if (d_rvalid) n_drv++;
      if (i_done) begin n_idn++; order_q.push_back(8'h49); if (i_rvalid) n_i_coinc++; end
      if (d_done) begin n_ddn++; order_q.push_back(8'h44); end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input bit side_d, input int maxc);
    int n = 0;
    while (!(side_d ? d_done : i_done) && n < maxc) begin
      step();
      n++;
    end
    chk(side_d ? "d_done_timeout" : "i_done_timeout", side_d ? d_done : i_done, 1);
  endtask

  initial begin
    int b, c_irv, c_idn, c_drv, c_ddn, c_co, o, n, k;
    logic [31:0] pat;

    // Reset state
    step(); step();
    chk("reset_mem_req", mem_req, 0);
    chk("reset_i_done", i_done, 0);
    chk("reset_d_rvalid", d_rvalid, 0);
    rst = 1'b1;
    step();

    // I refill alone, ready tied high
    b = log_addr.size(); c_irv = n_irv; c_idn = n_idn; c_co = n_i_coinc;
    i_addr = 32'h100; i_req = 1'b1; mem_ready = 1'b1;
    n = 0;
    while (!i_rvalid && n < 10) begin step(); n++; end
    chk("t1_latency", n, 2);
    wait_done(0, 20);
    i_req = 1'b0;
    step(); step();
    chk("t1_beats", log_addr.size() - b, 4);
    chk("t1_addr0", log_addr[b+0], 32'h100);
    chk("t1_addr1", log_addr[b+1], 32'h104);
    chk("t1_addr2", log_addr[b+2], 32'h108);
    chk("t1_addr3", log_addr[b+3], 32'h10C);
    chk("t1_rvalids", n_irv - c_irv, 4);
    chk("t1_done", n_idn - c_idn, 1);
    chk("t1_done_with_last", n_i_coinc - c_co, 1);

    // Simultaneous requests after reset: D, I, D alternation
    rst = 1'b0; step(); rst = 1'b1; step();
    b = log_addr.size(); o = order_q.size();
    i_addr = 32'h100; d_addr = 32'h400; d_we = 1'b0; i_req = 1'b1; d_req = 1'b1;
    k = 0; n = 0;
    while (k < 3 && n < 100) begin
      step(); n++;
      if (i_done || d_done) k++;
    end
    i_req = 1'b0; d_req = 1'b0;
    chk("t2_timeout", k, 3);
    step(); step();
    chk("t2_order0", order_q[o+0], 8'h44);
    chk("t2_order1", order_q[o+1], 8'h49);
    chk("t2_order2", order_q[o+2], 8'h44);
    chk("t2_first_addr", log_addr[b+0], 32'h400);
    chk("t2_second_addr", log_addr[b+4], 32'h100);
    chk("t2_third_addr", log_addr[b+8], 32'h400);

    // D store
    b = log_addr.size(); c_drv = n_drv; c_ddn = n_ddn;
    d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_req = 1'b1;
    wait_done(1, 20);
    d_req = 1'b0; d_we = 1'b0;
    step(); step();
    chk("t3_beats", log_addr.size() - b, 1);
    chk("t3_addr", log_addr[b], 32'h2000);
    chk("t3_wb", log_wb[b], 1);
    chk("t3_wdata", log_wdata[b], 32'hDEADBEEF);
    chk("t3_no_rvalid", n_drv - c_drv, 0);
    chk("t3_done", n_ddn - c_ddn, 1);

    // Stalled I burst, ready pattern 1,0,0,1,1,0,1; address changes after grant are ignored
    b = log_addr.size(); c_irv = n_irv; c_idn = n_idn;
    pat = 32'b1011001;   // bit 0 applied first
    mem_ready = 1'b0; i_addr = 32'h300; i_req = 1'b1;
    step();
    for (int j = 0; j < 7; j++) begin
      mem_ready = pat[j];
      i_addr = 32'hFFF0;
      step();
    end
    mem_ready = 1'b1;
    wait_done(0, 10);
    i_req = 1'b0;
    step(); step();
    chk("t4_beats", log_addr.size() - b, 4);
    chk("t4_addr0", log_addr[b+0], 32'h300);
    chk("t4_addr3", log_addr[b+3], 32'h30C);
    chk("t4_rvalids", n_irv - c_irv, 4);
    chk("t4_done", n_idn - c_idn, 1);

    // No regrant on the done cycle, regrant one cycle later
    i_addr = 32'h500; i_req = 1'b1;
    wait_done(0, 20);
    chk("t5_done_cycle_req", mem_req, 0);
    step();
    chk("t5_gap_req", mem_req, 0);
    step();
    chk("t5_regrant_req", mem_req, 1);
    chk("t5_regrant_addr", mem_addr, 32'h500);
    i_req = 1'b0;
    wait_done(0, 20);
    step(); step();

    // Reset after two beats aborts the burst; a fresh request restarts at base
    b = log_addr.size(); c_idn = n_idn;
    i_addr = 32'h600; i_req = 1'b1;
    step(); step(); step();
    chk("t6_beats_before_rst", log_addr.size() - b, 2);
    rst = 1'b0; i_req = 1'b0;
    #1;
    chk("t6_rst_mem_req", mem_req, 0);
    chk("t6_rst_mem_addr", mem_addr, 0);
    chk("t6_rst_i_rvalid", i_rvalid, 0);
    step();
    rst = 1'b1;
    step(); step(); step();
    chk("t6_no_done", n_idn - c_idn, 0);
    b = log_addr.size();
    i_req = 1'b1;
    wait_done(0, 20);
    i_req = 1'b0;
    step(); step();
    chk("t6_restart_addr", log_addr[b], 32'h600);
    chk("t6_restart_beats", log_addr.size() - b, 4);
    chk("t6_done", n_idn - c_idn, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
